// File: rtl/arb_pkg.sv
// Shared defaults and state encoding for the round-robin encoded arbiter.
package arb_pkg;

    localparam int NUM_REQ_DEF = 16;
    localparam int ID_W_DEF    = 4;

    // Wide enough for any MAX_HOLD in 2..255.
    localparam int HOLD_CNT_W  = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        TURN  = 2'd2
    } arb_state_t;

endpackage : arb_pkg

// File: rtl/rr_priority_encoder.sv
// Round-robin winner search: rotate the request vector so the search begins
// just above last_id, pick the lowest set bit, then map back to a real index.
module rr_priority_encoder
    import arb_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int ID_W    = ID_W_DEF
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    last_id,
    output logic               any,
    output logic [ID_W-1:0]    winner_id
);

    logic [ID_W-1:0]      start;
    logic [2*NUM_REQ-1:0] dbl_shift;
    logic [NUM_REQ-1:0]   rot;
    logic [ID_W-1:0]      off;
    logic [ID_W:0]        sum;

    // Rotate, priority-encode the lowest set bit, un-rotate modulo NUM_REQ.
    always_comb begin
        start     = (last_id == ID_W'(NUM_REQ - 1)) ? '0 : last_id + ID_W'(1);
        // Doubling req lets a plain right shift act as a rotate.
        dbl_shift = {req, req} >> start;
        rot       = dbl_shift[NUM_REQ-1:0];
        off       = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off = ID_W'(i);
            end
        end
        sum = {1'b0, start} + {1'b0, off};
        if (sum >= (ID_W + 1)'(NUM_REQ)) begin
            sum = sum - (ID_W + 1)'(NUM_REQ);
        end
        winner_id = sum[ID_W-1:0];
        any       = |req;
    end

endmodule : rr_priority_encoder

// File: rtl/arb_rr_encoded.sv
// Round-robin arbiter with registered one-hot and binary grant, a per-grant
// hold limit (MAX_HOLD) and a mandatory one-cycle turnaround between grants.
module arb_rr_encoded
    import arb_pkg::*;
#(
    parameter int NUM_REQ  = NUM_REQ_DEF,
    parameter int ID_W     = ID_W_DEF,
    parameter int MAX_HOLD = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_W-1:0]    gnt_id,
    output logic               gnt_valid,
    output logic               timeout
);

    arb_state_t              state_q, state_d;
    logic [NUM_REQ-1:0]      gnt_q, gnt_d;
    logic [ID_W-1:0]         gnt_id_q, gnt_id_d;
    logic                    gnt_valid_q, gnt_valid_d;
    logic                    timeout_q, timeout_d;
    logic [HOLD_CNT_W-1:0]   cnt_q, cnt_d;
    logic [ID_W-1:0]         last_id_q, last_id_d;

    logic                    any;
    logic [ID_W-1:0]         winner_id;

    rr_priority_encoder #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_enc (
        .req       (req),
        .last_id   (last_id_q),
        .any       (any),
        .winner_id (winner_id)
    );

    // State, counter, last winner and all outputs live in these flops.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            gnt_q       <= '0;
            gnt_id_q    <= '0;
            gnt_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
            cnt_q       <= '0;
            // First search after reset then starts at index 0.
            last_id_q   <= ID_W'(NUM_REQ - 1);
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            gnt_id_q    <= gnt_id_d;
            gnt_valid_q <= gnt_valid_d;
            timeout_q   <= timeout_d;
            cnt_q       <= cnt_d;
            last_id_q   <= last_id_d;
        end
    end

    // Next-state and next-output logic; timeout is a pulse so it defaults low.
    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        gnt_id_d    = gnt_id_q;
        gnt_valid_d = gnt_valid_q;
        timeout_d   = 1'b0;
        cnt_d       = cnt_q;
        last_id_d   = last_id_q;
        case (state_q)
            IDLE: begin
                if (enable && any) begin
                    state_d     = GRANT;
                    gnt_d       = NUM_REQ'(1) << winner_id;
                    gnt_id_d    = winner_id;
                    gnt_valid_d = 1'b1;
                    cnt_d       = '0;
                    last_id_d   = winner_id;
                end
            end
            GRANT: begin
                // Release is checked first so a release on the last allowed
                // cycle is never reported as a timeout.
                if (!req[gnt_id_q]) begin
                    state_d     = TURN;
                    gnt_d       = '0;
                    gnt_valid_d = 1'b0;
                end else if (cnt_q == HOLD_CNT_W'(MAX_HOLD - 1)) begin
                    state_d     = TURN;
                    gnt_d       = '0;
                    gnt_valid_d = 1'b0;
                    timeout_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + HOLD_CNT_W'(1);
                end
            end
            TURN: begin
                state_d = IDLE;
            end
            default: begin
                state_d     = IDLE;
                gnt_d       = '0;
                gnt_valid_d = 1'b0;
            end
        endcase
    end

    assign gnt       = gnt_q;
    assign gnt_id    = gnt_id_q;
    assign gnt_valid = gnt_valid_q;
    assign timeout   = timeout_q;

endmodule : arb_rr_encoded

// File: tb/tb_arb_rr_encoded.sv
// Directed bench for arb_rr_encoded: a per-cycle vector table followed by
// hand-written sequences for round-robin wrap, hold timeout and reset.
module tb_arb_rr_encoded;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [15:0] req;
    logic [15:0] gnt;
    logic [3:0]  gnt_id;
    logic        gnt_valid;
    logic        timeout;

    int checks = 0;
    int errors = 0;

    arb_rr_encoded #(
        .NUM_REQ  (16),
        .ID_W     (4),
        .MAX_HOLD (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .req       (req),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        rst;
        logic        en;
        logic [15:0] req;
        logic [15:0] gnt;
        logic [3:0]  id;
        logic        v;
        logic        to;
    } vec_t;

    vec_t tbl [0:17];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int gap;
        int vcount;
        int id;

        //                rst   en    req       gnt       id    v     to
        tbl[0]  = '{1'b1, 1'b0, 16'h0000, 16'h0000, 4'd0, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 1'b1, 16'h0001, 16'h0001, 4'd0, 1'b1, 1'b0};
        tbl[2]  = '{1'b0, 1'b1, 16'h0001, 16'h0001, 4'd0, 1'b1, 1'b0};
        tbl[3]  = '{1'b0, 1'b1, 16'h0000, 16'h0000, 4'd0, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 1'b1, 16'h0000, 16'h0000, 4'd0, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 1'b0, 16'h0300, 16'h0000, 4'd0, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 1'b0, 16'h0300, 16'h0000, 4'd0, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 1'b1, 16'h0300, 16'h0100, 4'd8, 1'b1, 1'b0};
        tbl[8]  = '{1'b0, 1'b0, 16'h0300, 16'h0100, 4'd8, 1'b1, 1'b0};
        tbl[9]  = '{1'b0, 1'b0, 16'h0200, 16'h0000, 4'd8, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 1'b0, 16'h0200, 16'h0000, 4'd8, 1'b0, 1'b0};
        tbl[11] = '{1'b0, 1'b1, 16'h0200, 16'h0200, 4'd9, 1'b1, 1'b0};
        tbl[12] = '{1'b0, 1'b1, 16'h0202, 16'h0200, 4'd9, 1'b1, 1'b0};
        tbl[13] = '{1'b0, 1'b1, 16'h0002, 16'h0000, 4'd9, 1'b0, 1'b0};
        tbl[14] = '{1'b0, 1'b1, 16'h0002, 16'h0000, 4'd9, 1'b0, 1'b0};
        tbl[15] = '{1'b0, 1'b1, 16'h0002, 16'h0002, 4'd1, 1'b1, 1'b0};
        tbl[16] = '{1'b1, 1'b1, 16'h0002, 16'h0000, 4'd0, 1'b0, 1'b0};
        tbl[17] = '{1'b0, 1'b1, 16'h0000, 16'h0000, 4'd0, 1'b0, 1'b0};

        reset  = 1'b1;
        enable = 1'b0;
        req    = 16'h0000;
        step();
        step();

        // Vector table: each row is driven, one edge taken, outputs compared.
        for (int i = 0; i < 18; i++) begin
            reset  = tbl[i].rst;
            enable = tbl[i].en;
            req    = tbl[i].req;
            step();
            chk($sformatf("row%0d gnt", i),       32'(gnt),       32'(tbl[i].gnt));
            chk($sformatf("row%0d gnt_id", i),    32'(gnt_id),    32'(tbl[i].id));
            chk($sformatf("row%0d gnt_valid", i), 32'(gnt_valid), 32'(tbl[i].v));
            chk($sformatf("row%0d timeout", i),   32'(timeout),   32'(tbl[i].to));
        end

        // Round-robin over all requesters with wrap back to 0.
        enable = 1'b1;
        req    = 16'hFFFF;
        reset  = 1'b1;
        step();
        reset  = 1'b0;
        for (int k = 0; k <= 16; k++) begin
            gap = 1;
            step();
            while (!gnt_valid && gap < 10) begin
                gap++;
                step();
            end
            id = k % 16;
            chk($sformatf("rr%0d gnt_id", k), 32'(gnt_id), 32'(id));
            chk($sformatf("rr%0d gnt", k), 32'(gnt), 32'(16'h0001 << id));
            // A TURN cycle and an IDLE cycle separate consecutive grants.
            if (k > 0) chk($sformatf("rr%0d gap", k), 32'(gap), 32'd2);
            step();
            chk($sformatf("rr%0d hold", k), 32'(gnt_valid), 32'd1);
            req = 16'hFFFF & ~(16'h0001 << id);
            step();
            chk($sformatf("rr%0d release", k), 32'(gnt_valid), 32'd0);
            chk($sformatf("rr%0d no_to", k), 32'(timeout), 32'd0);
            req = 16'hFFFF;
        end

        // Continuous request is revoked after exactly MAX_HOLD cycles.
        req = 16'h0000;
        do_reset();
        req = 16'h0004;
        step();
        chk("to first gnt_id", 32'(gnt_id), 32'd2);
        vcount = 1;
        while (gnt_valid && vcount < 20) begin
            step();
            if (gnt_valid) vcount++;
        end
        chk("to valid cycles", 32'(vcount), 32'd8);
        chk("to pulse", 32'(timeout), 32'd1);
        chk("to turn gnt_id", 32'(gnt_id), 32'd2);
        chk("to turn gnt", 32'(gnt), 32'd0);
        step();
        chk("to pulse end", 32'(timeout), 32'd0);
        chk("to idle valid", 32'(gnt_valid), 32'd0);
        step();
        chk("to regrant valid", 32'(gnt_valid), 32'd1);
        chk("to regrant id", 32'(gnt_id), 32'd2);

        // Release coinciding with the last allowed cycle is not a timeout.
        req = 16'h0000;
        do_reset();
        req = 16'h0020;
        step();
        chk("caseA gnt_id", 32'(gnt_id), 32'd5);
        for (int c = 1; c <= 7; c++) begin
            step();
            chk($sformatf("caseA hold%0d", c), 32'(gnt_valid), 32'd1);
        end
        req = 16'h0000;
        step();
        chk("caseA valid", 32'(gnt_valid), 32'd0);
        chk("caseA timeout", 32'(timeout), 32'd0);
        step();
        chk("caseA timeout late", 32'(timeout), 32'd0);

        // Reset in the middle of a grant to id 9.
        do_reset();
        req = 16'h0200;
        step();
        chk("rst gnt_id before", 32'(gnt_id), 32'd9);
        step();
        reset = 1'b1;
        req   = 16'hFFFF;
        step();
        chk("rst gnt", 32'(gnt), 32'd0);
        chk("rst gnt_id", 32'(gnt_id), 32'd0);
        chk("rst valid", 32'(gnt_valid), 32'd0);
        chk("rst timeout", 32'(timeout), 32'd0);
        reset = 1'b0;
        step();
        chk("rst first gnt_id", 32'(gnt_id), 32'd0);
        chk("rst first gnt", 32'(gnt), 32'h0001);
        chk("rst first valid", 32'(gnt_valid), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_arb_rr_encoded
